// File: rtl/gray_codec_pipe.sv
// Registered Gray-code codec: bin->gray, gray->bin, gray increment/decrement,
// behind a single valid/ready register stage (one word per cycle, 1-cycle latency).
module gray_codec_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic             out_wrap
);

  typedef enum logic [1:0] {
    MODE_B2G = 2'b00,
    MODE_G2B = 2'b01,
    MODE_INC = 2'b10,
    MODE_DEC = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      g[i] = b[i] ^ b[i+1];
    end
    return g;
  endfunction

  // Prefix XOR from the MSB; linear depth is acceptable up to 32 bits.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  mode_e            w_mode;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_result;
  logic             w_wrap;
  logic             w_in_fire;
  logic             w_out_fire;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_mode;
  logic             r_wrap;

  always_comb begin
    w_mode   = mode_e'(in_mode);
    w_bin    = gray2bin(in_data);
    w_step   = w_bin;
    w_result = '0;
    w_wrap   = 1'b0;
    case (w_mode)
      MODE_B2G: w_result = bin2gray(in_data);
      MODE_G2B: w_result = w_bin;
      MODE_INC: begin
        w_step   = w_bin + ONE;
        w_result = bin2gray(w_step);
        w_wrap   = &w_bin;
      end
      MODE_DEC: begin
        w_step   = w_bin - ONE;
        w_result = bin2gray(w_step);
        w_wrap   = ~|w_bin;
      end
      default: w_result = '0;
    endcase
  end

  assign in_ready   = !r_valid || out_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_valid && out_ready;

  // A new input always wins over draining, so simultaneous in/out keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= 2'b00;
      r_wrap  <= 1'b0;
    end else if (w_in_fire) begin
      r_valid <= 1'b1;
      r_data  <= w_result;
      r_mode  <= in_mode;
      r_wrap  <= w_wrap;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_mode  = r_mode;
  assign out_wrap  = r_wrap;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Scoreboard bench for gray_codec_pipe: a WIDTH=4 instance for directed/flow-control
// vectors and a WIDTH=8 instance for exhaustive round-trip and step chains.
module tb_gray_codec_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       inValid4, inReady4, outValid4, outReady4, outWrap4;
  logic [1:0] inMode4, outMode4;
  logic [3:0] inData4, outData4;

  logic       inValid8, inReady8, outValid8, outReady8, outWrap8;
  logic [1:0] inMode8, outMode8;
  logic [7:0] inData8, outData8;

  gray_codec_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid4), .in_ready(inReady4), .in_mode(inMode4), .in_data(inData4),
    .out_valid(outValid4), .out_ready(outReady4), .out_data(outData4),
    .out_mode(outMode4), .out_wrap(outWrap4)
  );

  gray_codec_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid8), .in_ready(inReady8), .in_mode(inMode8), .in_data(inData8),
    .out_valid(outValid8), .out_ready(outReady8), .out_data(outData8),
    .out_mode(outMode8), .out_wrap(outWrap8)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    logic        wrap;
    logic [31:0] operand;
  } expT;

  expT q4[$];
  expT q8[$];
  int  checks = 0;
  int  fails  = 0;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] data;
    logic [3:0] exp;
    logic       wrap;
  } vecT;

  // Hand-computed WIDTH=4 vectors: {mode, operand, result, wrap}.
  vecT vecs [16] = '{
    {2'b00, 4'b1011, 4'b1110, 1'b0},
    {2'b01, 4'b1110, 4'b1011, 1'b0},
    {2'b10, 4'b1000, 4'b0000, 1'b1},
    {2'b11, 4'b0000, 4'b1000, 1'b1},
    {2'b10, 4'b0000, 4'b0001, 1'b0},
    {2'b11, 4'b0001, 4'b0000, 1'b0},
    {2'b10, 4'b0110, 4'b0111, 1'b0},
    {2'b11, 4'b1100, 4'b0100, 1'b0},
    {2'b00, 4'b0111, 4'b0100, 1'b0},
    {2'b01, 4'b0100, 4'b0111, 1'b0},
    {2'b01, 4'b1000, 4'b1111, 1'b0},
    {2'b00, 4'b1111, 4'b1000, 1'b0},
    {2'b00, 4'b0000, 4'b0000, 1'b0},
    {2'b10, 4'b0100, 4'b1100, 1'b0},
    {2'b11, 4'b1001, 4'b1011, 1'b0},
    {2'b10, 4'b1011, 4'b1001, 1'b0}
  };

  function automatic logic [7:0] toGray8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] data, input logic [1:0] mode,
                             input logic wrap, input expT e);
    checks++;
    if (data !== e.data || mode !== e.mode || wrap !== e.wrap) begin
      fails++;
      $display("[TB] FAIL %s result: got data=0x%0h mode=%0d wrap=%0b, expected data=0x%0h mode=%0d wrap=%0b (operand 0x%0h)",
               name, data, mode, wrap, e.data, e.mode, e.wrap, e.operand);
    end
    if (e.mode[1]) begin
      checks++;
      if ($countones(data ^ e.operand) != 1) begin
        fails++;
        $display("[TB] FAIL %s step distance: got 0x%0h from 0x%0h, expected one bit change",
                 name, data, e.operand);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && outValid4 && outReady4) begin
      if (q4.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL dut4 unexpected output: got 0x%0h, expected none", outData4);
      end else begin
        checkOutput("dut4", {28'b0, outData4}, outMode4, outWrap4, q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && outValid8 && outReady8) begin
      if (q8.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL dut8 unexpected output: got 0x%0h, expected none", outData8);
      end else begin
        checkOutput("dut8", {24'b0, outData8}, outMode8, outWrap8, q8.pop_front());
      end
    end
  end

  // Leaves in_valid high on return so consecutive calls stream back-to-back.
  task automatic applyStimulus(input int dut, input logic [1:0] mode, input logic [31:0] data,
                               input logic [31:0] expData, input logic expWrap);
    expT e;
    bit  done = 0;
    e.data = expData; e.mode = mode; e.wrap = expWrap; e.operand = data;
    if (dut == 4) begin
      inValid4 = 1'b1; inMode4 = mode; inData4 = data[3:0];
    end else begin
      inValid8 = 1'b1; inMode8 = mode; inData8 = data[7:0];
    end
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if ((dut == 4) ? inReady4 : inReady8) begin
        if (dut == 4) q4.push_back(e); else q8.push_back(e);
        @(posedge clk);
        #1;
        done = 1;
        checkValue("outValidAfterTransfer", {31'b0, (dut == 4) ? outValid4 : outValid8}, 32'd1);
      end
    end
    if (!done) begin
      checks++; fails++;
      $display("[TB] FAIL dut%0d input transfer timeout: got in_ready=0, expected acceptance", dut);
    end
  endtask

  task automatic dropValid();
    inValid4 = 1'b0;
    inValid8 = 1'b0;
  endtask

  initial begin
    logic [7:0] g, nxt, bCur, bNext;
    longint t0;

    rst_n = 1'b0;
    inValid4 = 0; inMode4 = 0; inData4 = 0; outReady4 = 1;
    inValid8 = 0; inMode8 = 0; inData8 = 0; outReady8 = 1;
    #12;
    checkValue("reset dut4 outputs", {24'b0, outValid4, outMode4, outWrap4, outData4}, 32'd0);
    checkValue("reset dut8 outputs", {20'b0, outValid8, outMode8, outWrap8, outData8}, 32'd0);
    outReady4 = 1'b0;
    #1;
    checkValue("reset dut4 in_ready", {31'b0, inReady4}, 32'd1);
    checkValue("reset dut8 in_ready", {31'b0, inReady8}, 32'd1);
    outReady4 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors back-to-back on WIDTH=4");
    t0 = $time;
    foreach (vecs[i]) begin
      applyStimulus(4, vecs[i].mode, {28'b0, vecs[i].data}, {28'b0, vecs[i].exp}, vecs[i].wrap);
    end
    checkValue("back-to-back cycles", 32'(($time - t0) / 10), 32'd16);
    dropValid();

    $display("[TB] WIDTH=8 round trip and step chains");
    for (int v = 0; v < 256; v++) begin
      g = toGray8(8'(v));
      applyStimulus(8, 2'b00, 32'(v), {24'b0, g}, 1'b0);
      applyStimulus(8, 2'b01, {24'b0, g}, 32'(v), 1'b0);
    end
    g = 8'h00;
    for (int s = 0; s < 256; s++) begin
      nxt = toGray8(8'(s + 1));
      applyStimulus(8, 2'b10, {24'b0, g}, {24'b0, nxt}, s == 255);
      g = nxt;
    end
    bCur = 8'h00;
    for (int s = 0; s < 256; s++) begin
      bNext = bCur - 8'd1;
      applyStimulus(8, 2'b11, {24'b0, toGray8(bCur)}, {24'b0, toGray8(bNext)}, bCur == 8'h00);
      bCur = bNext;
    end
    dropValid();

    $display("[TB] backpressure on WIDTH=4");
    outReady4 = 1'b0;
    applyStimulus(4, vecs[7].mode, {28'b0, vecs[7].data}, {28'b0, vecs[7].exp}, vecs[7].wrap);
    for (int k = 0; k < 5; k++) begin
      inValid4 = 1'b1;
      inMode4  = 2'(k);
      inData4  = 4'(k * 3 + 1);
      @(negedge clk);
      checkValue("stall hold", {23'b0, inReady4, outValid4, outMode4, outWrap4, outData4},
                 {23'b0, 1'b0, 1'b1, 2'b11, 1'b0, 4'b0100});
      @(posedge clk);
      #1;
    end
    outReady4 = 1'b1;
    applyStimulus(4, vecs[13].mode, {28'b0, vecs[13].data}, {28'b0, vecs[13].exp}, vecs[13].wrap);
    dropValid();
    @(negedge clk);
    @(posedge clk);
    #1;

    $display("[TB] asynchronous reset mid-stream");
    outReady4 = 1'b0;
    applyStimulus(4, vecs[0].mode, {28'b0, vecs[0].data}, {28'b0, vecs[0].exp}, vecs[0].wrap);
    dropValid();
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("async reset outputs", {23'b0, inReady4, outValid4, outMode4, outWrap4, outData4},
               {23'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000});
    q4.delete();
    q8.delete();
    #2;
    rst_n = 1'b1;
    outReady4 = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(4, vecs[15].mode, {28'b0, vecs[15].data}, {28'b0, vecs[15].exp}, vecs[15].wrap);
    dropValid();

    for (int c = 0; c < 20 && (q4.size() + q8.size()) != 0; c++) begin
      @(negedge clk);
    end
    checkValue("scoreboard drained", 32'(q4.size() + q8.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
